mode_ctrl: RTL and testbench
============================

Name: mode_ctrl

Overview:
- Top-level operating-mode controller for the light-pen screen.
- Debounces four front-panel buttons, detects presses, and runs the mode state machine.
- Drives the state[2:0] / state_deep[2:0] pair that the seven-segment display driver and the drawing datapath consume.
- Sequences the power-on lamp-test blink, then sleep, wake, the drawing modes and pause.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, cycles a raw button must be stable before its debounced level changes (20 ms at 50 MHz).
- BLINK_CYCLES, 25_000_000, dwell time of each RST sub-step (0.5 s at 50 MHz).
- LIGHT_CYCLES, 100_000_000, maximum dwell in LIGHT before automatic advance to DRAW.

Ports:
- clk  in  1  system clock; only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- btn_power  in  1  raw power button, active-high, asynchronous to clk.
- btn_mode  in  1  raw mode-cycle button, active-high, asynchronous.
- btn_light  in  1  raw calibrate/light button, active-high, asynchronous.
- btn_stop  in  1  raw pause button, active-high, asynchronous.
- state  out  3  mode code: RST=0, SLEEP=1, LIGHT=2, DRAW=3, WRITE=4, ERASE=5, COLOR=6, STOP=7.
- state_deep  out  3  RST sub-step STATE_0..STATE_3 = 0..3; 0 in every other state.
- press_pulse  out  4  one-cycle press strobes {stop, light, mode, power}, after debounce.

Behaviour:
- Reset: all registers clear asynchronously.
  - state=RST(0), state_deep=0, press_pulse=0.
  - Debounced levels=0, counters=0, saved_state=DRAW.
- Input path: per button, a 2-flop synchronizer, then a debounce counter.
  - The counter reloads whenever the synchronized level equals the debounced level.
  - The debounced level toggles when the counter reaches DEBOUNCE_CYCLES-1.
  - press_pulse[i] is high for exactly one cycle on the debounced rising edge.
  - Latency from a stable raw edge to press_pulse is 2 + DEBOUNCE_CYCLES cycles, ±1.
  - Releases produce no pulse.
- Dwell timer: 27-bit counter, cleared on every state or state_deep change.
- State transitions are registered; outputs come straight from registers.
  - RST:
    - state_deep steps 0→1→2→3, each step held BLINK_CYCLES.
    - After step 3 expires, go to SLEEP with state_deep=0.
    - Buttons are ignored in RST.
  - SLEEP: power → LIGHT. All other presses are ignored.
  - LIGHT:
    - mode, or timer reaching LIGHT_CYCLES-1 → DRAW.
    - light → restart the LIGHT dwell timer.
  - DRAW/WRITE/ERASE/COLOR:
    - mode cycles DRAW→WRITE→ERASE→COLOR→DRAW.
    - light → LIGHT.
    - stop → STOP; the current state is saved in saved_state.
  - STOP:
    - stop → return to saved_state.
    - mode and light are ignored.
  - power from any state except RST and SLEEP → SLEEP; saved_state resets to DRAW.
- Simultaneous strobes in one cycle: priority is power > stop > light > mode. Only the winner acts.
- Encodings outside 0..7 cannot occur. If state_deep is ever non-zero outside RST, it is forced to 0 the next cycle.
- An asynchronous reset mid-operation returns to RST step 0 immediately. The blink sequence replays in full.

Test Plan:
- Run the bench with DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, LIGHT_CYCLES=20.
- Reset release, no buttons → state_deep is 0,1,2,3 for 8 cycles each. state=1 (SLEEP) at cycle 32 ±1; state_deep=0 thereafter.
- Bounce: toggle btn_power every 2 cycles for 20 cycles, then hold high for 10 cycles in SLEEP → exactly one press_pulse[0] and state=2 (LIGHT). No pulse during bouncing.
- Mode cycling: from DRAW press mode four times → state 4,5,6,3. In LIGHT with no press → state=3 after 20 cycles.
- Pause/resume: in ERASE(5) press stop → state=7. Press mode → stays 7. Press stop → state=5.
- Simultaneous: in WRITE(4) assert btn_power and btn_stop on the same cycle → state=1 (SLEEP). Then power → 2. Then a stop from DRAW saves DRAW, not WRITE.
- Reset mid-operation: assert rst_n=0 during COLOR → state=0 and state_deep=0 without waiting for a clock edge. On release the full blink sequence repeats.

Source files
------------

// File: rtl/mode_ctrl_if.sv
// Front-panel bundle between the button board and the mode controller:
// raw button levels in, mode code, blink sub-step and press strobes out.
interface mode_ctrl_if;
  logic       btn_power;
  logic       btn_mode;
  logic       btn_light;
  logic       btn_stop;
  logic [2:0] state;
  logic [2:0] state_deep;
  logic [3:0] press_pulse;

  modport master (
    output btn_power, btn_mode, btn_light, btn_stop,
    input  state, state_deep, press_pulse
  );

  modport slave (
    input  btn_power, btn_mode, btn_light, btn_stop,
    output state, state_deep, press_pulse
  );
endinterface

// File: rtl/mode_ctrl.sv
// Operating-mode controller for the light-pen screen: button synchronise and
// debounce, press strobes, power-on lamp-test blink and the mode state machine.
module mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_CYCLES    = 25_000_000,
  parameter int LIGHT_CYCLES    = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  mode_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_SLEEP = 3'd1,
    ST_LIGHT = 3'd2,
    ST_DRAW  = 3'd3,
    ST_WRITE = 3'd4,
    ST_ERASE = 3'd5,
    ST_COLOR = 3'd6,
    ST_STOP  = 3'd7
  } mode_t;

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [3:0] raw;
  logic [3:0] pulse_vec;

  assign raw = {bus.btn_stop, bus.btn_light, bus.btn_mode, bus.btn_power};

  // One synchroniser + debouncer per button; bit order {stop, light, mode, power}.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      logic          sync1_reg;
      logic          sync2_reg;
      logic          deb_reg;
      logic          pulse_reg;
      logic [DW-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          deb_reg   <= 1'b0;
          pulse_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          pulse_reg <= 1'b0;
          if (sync2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb_reg   <= ~deb_reg;
            cnt_reg   <= '0;
            pulse_reg <= ~deb_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign pulse_vec[gi] = pulse_reg;
    end
  endgenerate

  mode_t       state_reg, state_next;
  mode_t       saved_reg, saved_next;
  logic [2:0]  deep_reg, deep_next;
  logic [26:0] timer_reg;
  logic        restart;
  logic        blink_done, light_done;
  logic        p_power, p_stop, p_light, p_mode;

  // Only the highest-priority strobe of a cycle is allowed to act.
  assign p_power = pulse_vec[0];
  assign p_stop  = pulse_vec[3] & ~pulse_vec[0];
  assign p_light = pulse_vec[2] & ~pulse_vec[3] & ~pulse_vec[0];
  assign p_mode  = pulse_vec[1] & ~pulse_vec[2] & ~pulse_vec[3] & ~pulse_vec[0];

  assign blink_done = (timer_reg == 27'(BLINK_CYCLES - 1));
  assign light_done = (timer_reg == 27'(LIGHT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RST;
      saved_reg <= ST_DRAW;
      deep_reg  <= 3'd0;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      saved_reg <= saved_next;
      deep_reg  <= deep_next;
      if (state_next != state_reg || deep_next != deep_reg || restart)
        timer_reg <= '0;
      else
        timer_reg <= timer_reg + 27'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    saved_next = saved_reg;
    deep_next  = 3'd0;
    restart    = 1'b0;
    case (state_reg)
      ST_RST: begin
        deep_next = deep_reg;
        if (blink_done) begin
          if (deep_reg >= 3'd3) begin
            state_next = ST_SLEEP;
            deep_next  = 3'd0;
          end else begin
            deep_next = deep_reg + 3'd1;
          end
        end
      end
      ST_SLEEP: begin
        if (p_power) state_next = ST_LIGHT;
      end
      ST_LIGHT: begin
        if (p_power) begin
          state_next = ST_SLEEP;
          saved_next = ST_DRAW;
        end else if (p_light) begin
          restart = 1'b1;
        end else if (p_mode || light_done) begin
          state_next = ST_DRAW;
        end
      end
      ST_DRAW, ST_WRITE, ST_ERASE, ST_COLOR: begin
        if (p_power) begin
          state_next = ST_SLEEP;
          saved_next = ST_DRAW;
        end else if (p_stop) begin
          saved_next = state_reg;
          state_next = ST_STOP;
        end else if (p_light) begin
          state_next = ST_LIGHT;
        end else if (p_mode) begin
          state_next = (state_reg == ST_COLOR) ? ST_DRAW : mode_t'(3'(state_reg) + 3'd1);
        end
      end
      ST_STOP: begin
        if (p_power) begin
          state_next = ST_SLEEP;
          saved_next = ST_DRAW;
        end else if (p_stop) begin
          state_next = saved_reg;
        end
      end
      default: state_next = ST_RST;
    endcase
  end

  assign bus.state       = 3'(state_reg);
  assign bus.state_deep  = deep_reg;
  assign bus.press_pulse = pulse_vec;

endmodule

// File: tb/tb_mode_ctrl.sv
// Randomised scoreboard bench for mode_ctrl: a mode-rule model queues expected
// state changes and press strobes with timing windows; a monitor pops and compares.
module tb_mode_ctrl;
  localparam int DC = 4;
  localparam int BC = 8;
  localparam int LC = 20;

  localparam int RST = 0, SLEEP = 1, LIGHT = 2, DRAW = 3, WRITE = 4, ERASE = 5, COLOR = 6, STOP = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  mode_ctrl_if bus ();

  mode_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .BLINK_CYCLES   (BC),
    .LIGHT_CYCLES   (LC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] st;
    logic [2:0] dp;
    int         lo;
    int         hi;
  } sev_t;

  typedef struct {
    logic [3:0] m;
    int         lo;
    int         hi;
  } pev_t;

  sev_t sq[$];
  pev_t pq[$];

  // Reference model: the mode and the saved return mode, updated per press.
  int m_state = RST;
  int m_saved = DRAW;
  int light_entry = 0;

  function automatic int winner(input logic [3:0] m);
    if (m[0]) return 0;
    if (m[3]) return 3;
    if (m[2]) return 2;
    if (m[1]) return 1;
    return -1;
  endfunction

  function automatic bit is_drawing(input int s);
    return (s >= DRAW && s <= COLOR);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_state(input int st, input int dp, input int lo, input int hi);
    sev_t e;
    e.st = 3'(st);
    e.dp = 3'(dp);
    e.lo = lo;
    e.hi = hi;
    sq.push_back(e);
  endtask

  task automatic push_blink(input int r);
    for (int k = 1; k <= 3; k++) push_state(RST, k, r + BC * k - 1, r + BC * k + 1);
    push_state(SLEEP, 0, r + 4 * BC - 1, r + 4 * BC + 1);
  endtask

  // Apply the mode rules to one set of simultaneous presses.
  task automatic model_apply(input logic [3:0] m, output bit changed, output bit rst_timer);
    int old = m_state;
    rst_timer = 1'b0;
    case (winner(m))
      0: begin
        if (m_state == SLEEP) m_state = LIGHT;
        else if (m_state != RST) begin
          m_state = SLEEP;
          m_saved = DRAW;
        end
      end
      3: begin
        if (is_drawing(m_state)) begin
          m_saved = m_state;
          m_state = STOP;
        end else if (m_state == STOP) begin
          m_state = m_saved;
        end
      end
      2: begin
        if (is_drawing(m_state)) m_state = LIGHT;
        else if (m_state == LIGHT) rst_timer = 1'b1;
      end
      1: begin
        if (m_state == LIGHT) m_state = DRAW;
        else if (is_drawing(m_state)) m_state = (m_state == COLOR) ? DRAW : m_state + 1;
      end
      default: ;
    endcase
    changed = (m_state != old);
  endtask

  task automatic set_btns(input logic [3:0] m);
    bus.btn_power = m[0];
    bus.btn_mode  = m[1];
    bus.btn_light = m[2];
    bus.btn_stop  = m[3];
  endtask

  // Queue expectations for a clean press starting at cycle c.
  task automatic expect_press(input logic [3:0] m, input int c);
    pev_t p;
    bit   ch, rt;
    p.m  = m;
    p.lo = c + DC + 1;
    p.hi = c + DC + 3;
    pq.push_back(p);
    model_apply(m, ch, rt);
    if (ch) push_state(m_state, 0, c + DC + 2, c + DC + 4);
    if ((ch && m_state == LIGHT) || rt) light_entry = c + DC + 3;
    $display("t=%0d press mask=%b expect state=%0d saved=%0d", c, m, m_state, m_saved);
  endtask

  task automatic do_press(input logic [3:0] m);
    int c = cyc;
    set_btns(m);
    expect_press(m, c);
    tick(DC + 3);
    set_btns(4'b0000);
    tick(DC + 4);
  endtask

  task automatic do_timeout();
    int t = light_entry + LC;
    push_state(DRAW, 0, t - 2, t + 2);
    m_state = DRAW;
    $display("t=%0d light timeout expect state=%0d near cycle %0d", cyc, m_state, t);
    while (cyc < t + 4) tick(1);
  endtask

  task automatic do_reset_release();
    int r;
    rst_n = 1'b1;
    r = cyc;
    push_blink(r);
    m_state = SLEEP;
    m_saved = DRAW;
    $display("t=%0d reset release expect blink then state=%0d", r, SLEEP);
    tick(4 * BC + 8);
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every change on state/state_deep and every strobe pops one expectation.
  logic [2:0] prev_st, prev_dp;
  sev_t se;
  pev_t pe;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_st = bus.state;
      prev_dp = bus.state_deep;
    end else begin
      if (bus.state != prev_st || bus.state_deep != prev_dp) begin
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL state_event: unexpected state=%0d deep=%0d at cycle %0d", bus.state, bus.state_deep, cyc);
        end else begin
          se = sq.pop_front();
          if (bus.state != se.st || bus.state_deep != se.dp || cyc < se.lo || cyc > se.hi) begin
            errors++;
            $display("FAIL state_event: got state=%0d deep=%0d at cycle %0d, expected state=%0d deep=%0d in cycles %0d..%0d",
                     bus.state, bus.state_deep, cyc, se.st, se.dp, se.lo, se.hi);
          end
        end
        prev_st = bus.state;
        prev_dp = bus.state_deep;
      end
      if (sq.size() > 0 && cyc > sq[0].hi) begin
        checks++;
        errors++;
        $display("FAIL state_missing: state=%0d deep=%0d still %0d/%0d at cycle %0d, expected state=%0d deep=%0d by cycle %0d",
                 bus.state, bus.state_deep, bus.state, bus.state_deep, cyc, sq[0].st, sq[0].dp, sq[0].hi);
        void'(sq.pop_front());
      end
      if (bus.press_pulse != 4'b0000) begin
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL press_pulse: unexpected %b at cycle %0d, expected none", bus.press_pulse, cyc);
        end else begin
          pe = pq.pop_front();
          if (bus.press_pulse != pe.m || cyc < pe.lo || cyc > pe.hi) begin
            errors++;
            $display("FAIL press_pulse: got %b at cycle %0d, expected %b in cycles %0d..%0d",
                     bus.press_pulse, cyc, pe.m, pe.lo, pe.hi);
          end
        end
      end
      if (pq.size() > 0 && cyc > pq[0].hi) begin
        checks++;
        errors++;
        $display("FAIL pulse_missing: got none by cycle %0d, expected %b", cyc, pq[0].m);
        void'(pq.pop_front());
      end
    end
  end

  initial begin
    logic [3:0] m;
    int h;
    set_btns(4'b0000);
    #2 rst_n = 1'b0;
    tick(3);
    check_val("reset_state", int'(bus.state), RST);
    check_val("reset_deep", int'(bus.state_deep), 0);
    check_val("reset_pulse", int'(bus.press_pulse), 0);
    do_reset_release();

    // Bouncing power button: no strobe while it chatters, one strobe once it settles.
    for (int k = 0; k < 10; k++) begin
      bus.btn_power = (k % 2 == 0);
      tick(2);
    end
    h = cyc;
    bus.btn_power = 1'b1;
    expect_press(4'b0001, h);
    tick(10);
    bus.btn_power = 1'b0;
    tick(DC + 4);

    // Mode cycling, light re-entry and LIGHT timeout.
    do_press(4'b0010);
    for (int k = 0; k < 4; k++) do_press(4'b0010);
    do_press(4'b0100);
    do_timeout();

    // Pause and resume from ERASE.
    do_press(4'b0010);
    do_press(4'b0010);
    do_press(4'b1000);
    do_press(4'b0010);
    do_press(4'b1000);

    // Simultaneous power+stop in WRITE, then a stop from DRAW must save DRAW.
    do_press(4'b0010);
    do_press(4'b0010);
    do_press(4'b0010);
    do_press(4'b1001);
    do_press(4'b0001);
    do_press(4'b0010);
    do_press(4'b1000);
    do_press(4'b1000);

    // Asynchronous reset in COLOR, checked between clock edges.
    do_press(4'b0010);
    do_press(4'b0010);
    do_press(4'b0010);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_reset_state", int'(bus.state), RST);
    check_val("async_reset_deep", int'(bus.state_deep), 0);
    tick(2);
    do_reset_release();

    // Random presses, including multi-button combinations.
    for (int n = 0; n < 60; n++) begin
      if (m_state == LIGHT && $urandom_range(0, 3) == 0) begin
        do_timeout();
      end else begin
        do begin
          if ($urandom_range(0, 1) == 0) m = 4'(1 << $urandom_range(0, 3));
          else m = 4'($urandom_range(1, 15));
        end while (m_state == LIGHT && winner(m) == 3);
        do_press(m);
      end
    end

    tick(10);
    check_val("state_queue_drained", sq.size(), 0);
    check_val("pulse_queue_drained", pq.size(), 0);
    check_val("final_state", int'(bus.state), m_state);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
